// File: rtl/dual_port_ram.sv
// True dual-port RAM, one clock. Port A wins dual-write collisions; a port that
// writes and reads at once sees its own write data, while the other port sees the old word.
module dual_port_ram_rdport #(
  parameter int DATA_WIDTH   = 56,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rden_i,
  input  logic [DATA_WIDTH-1:0] rd_word_i,
  output logic [DATA_WIDTH-1:0] q_o
);
  logic [DATA_WIDTH-1:0] s1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      s1_q <= '0;
    else if (rden_i) s1_q <= rd_word_i;
  end

  if (READ_LATENCY == 1) begin : g_lat1
    assign q_o = s1_q;
  end else begin : g_lat2
    // Output stage only advances behind an issued read, so idle cycles hold q.
    logic                  vld1_q;
    logic [DATA_WIDTH-1:0] s2_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld1_q <= 1'b0;
        s2_q   <= '0;
      end else begin
        vld1_q <= rden_i;
        if (vld1_q) s2_q <= s1_q;
      end
    end
    assign q_o = s2_q;
  end
endmodule

module dual_port_ram #(
  parameter int ADDR_WIDTH   = 11,
  parameter int DATA_WIDTH   = 56,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] address_a,
  input  logic                  wren_a,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic                  rden_a,
  output logic [DATA_WIDTH-1:0] q_a,
  input  logic [ADDR_WIDTH-1:0] address_b,
  input  logic                  wren_b,
  input  logic [DATA_WIDTH-1:0] data_b,
  input  logic                  rden_b,
  output logic [DATA_WIDTH-1:0] q_b
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Power-up contents are zero; the array itself never sees reset.
  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1] = '{default: '0};

  logic [1:0][ADDR_WIDTH-1:0] addr;
  logic [1:0][DATA_WIDTH-1:0] wdat, rd_word, q;
  logic [1:0]                 wren, rden;

  assign addr = {address_b, address_a};
  assign wdat = {data_b, data_a};
  assign wren = {wren_b, wren_a};
  assign rden = {rden_b, rden_a};
  assign {q_b, q_a} = q;

  // Port A's write is scheduled last, so it overrides port B on the same word.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (wren_b) mem[address_b] <= data_b;
      if (wren_a) mem[address_a] <= data_a;
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    assign rd_word[p] = wren[p] ? wdat[p] : mem[addr[p]];

    dual_port_ram_rdport #(
      .DATA_WIDTH  (DATA_WIDTH),
      .READ_LATENCY(READ_LATENCY)
    ) u_rd (
      .clk      (clk),
      .rst_n    (rst_n),
      .rden_i   (rden[p]),
      .rd_word_i(rd_word[p]),
      .q_o      (q[p])
    );
  end
endmodule

// File: tb/tb_dual_port_ram.sv
// Bench for dual_port_ram: latency-1 and latency-2 instances share stimulus and are
// checked against an array/register model derived from the read/write rules.
module tb_dual_port_ram;
  localparam int AW = 11;
  localparam int DW = 56;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] address_a, address_b;
  logic          wren_a, wren_b, rden_a, rden_b;
  logic [DW-1:0] data_a, data_b;
  logic [DW-1:0] q_a1, q_b1, q_a2, q_b2;

  int total = 0;
  int bad   = 0;

  // Model: memory, last-read word per port, and the delayed view for latency 2.
  logic [DW-1:0] mm [0:(1<<AW)-1];
  logic [DW-1:0] s1a, s1b, e2a, e2b;
  logic          v1a, v1b;

  localparam logic [DW-1:0] V5   = 56'h00FF00_0000FF_41;
  localparam logic [DW-1:0] V100 = 56'h123456789ABCDE;

  always #5 clk = ~clk;

  dual_port_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1)) u_l1 (
    .clk(clk), .rst_n(rst_n),
    .address_a(address_a), .wren_a(wren_a), .data_a(data_a), .rden_a(rden_a), .q_a(q_a1),
    .address_b(address_b), .wren_b(wren_b), .data_b(data_b), .rden_b(rden_b), .q_b(q_b1));

  dual_port_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(2)) u_l2 (
    .clk(clk), .rst_n(rst_n),
    .address_a(address_a), .wren_a(wren_a), .data_a(data_a), .rden_a(rden_a), .q_a(q_a2),
    .address_b(address_b), .wren_b(wren_b), .data_b(data_b), .rden_b(rden_b), .q_b(q_b2));

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic wa, input int aa, input logic [DW-1:0] da, input logic ra,
                       input logic wb, input int ab, input logic [DW-1:0] db, input logic rb);
    wren_a = wa; address_a = AW'(aa); data_a = da; rden_a = ra;
    wren_b = wb; address_b = AW'(ab); data_b = db; rden_b = rb;
  endtask

  task automatic idle();
    drive(0, 0, '0, 0, 0, 0, '0, 0);
  endtask

  task automatic model_reset();
    s1a = '0; s1b = '0; e2a = '0; e2b = '0; v1a = 1'b0; v1b = 1'b0;
  endtask

  // One clock edge: advance the model from the applied inputs, then check all outputs.
  task automatic tick();
    logic [DW-1:0] ra, rb;
    @(posedge clk);
    if (rst_n) begin
      ra = wren_a ? data_a : mm[address_a];
      rb = wren_b ? data_b : mm[address_b];
      if (v1a) e2a = s1a;
      if (v1b) e2b = s1b;
      v1a = rden_a;
      v1b = rden_b;
      if (rden_a) s1a = ra;
      if (rden_b) s1b = rb;
      if (wren_b) mm[address_b] = data_b;
      if (wren_a) mm[address_a] = data_a;
    end
    #1;
    chk("qa_l1", q_a1, s1a);
    chk("qb_l1", q_b1, s1b);
    chk("qa_l2", q_a2, e2a);
    chk("qb_l2", q_b2, e2b);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mm[i] = '0;
    model_reset();
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_qa_l1", q_a1, '0);
    chk("rst_qb_l1", q_b1, '0);
    chk("rst_qa_l2", q_a2, '0);
    chk("rst_qb_l2", q_b2, '0);
    rst_n = 1'b1;

    // Basic write on A, read on B
    drive(1, 5, V5, 0, 0, 0, '0, 0); tick();
    drive(0, 0, '0, 0, 0, 5, '0, 1); tick();
    chk("basic_l1", q_b1, V5);
    chk("basic_l2_pre", q_b2, '0);
    idle(); tick();
    chk("basic_l2", q_b2, V5);
    drive(0, 0, '0, 0, 0, 6, '0, 1); tick();
    chk("unwritten_l1", q_b1, '0);

    // Latency-2 timing and hold
    drive(1, 100, V100, 0, 0, 0, '0, 0); tick();
    drive(0, 0, '0, 0, 0, 100, '0, 1); tick();
    chk("lat2_edge1", q_b2, '0);
    chk("lat1_100", q_b1, V100);
    idle(); tick();
    chk("lat2_edge2", q_b2, V100);
    tick(); tick();
    chk("lat2_hold", q_b2, V100);

    // Cross-port collision is read-first; same-port is write-first
    drive(1, 7, 56'h1, 0, 0, 0, '0, 0); tick();
    drive(1, 7, 56'h2, 0, 0, 7, '0, 1); tick();
    chk("cross_old", q_b1, 56'h1);
    drive(0, 0, '0, 0, 0, 7, '0, 1); tick();
    chk("cross_new", q_b1, 56'h2);
    drive(1, 9, 56'h3, 1, 0, 0, '0, 0); tick();
    chk("same_port_wf", q_a1, 56'h3);

    // Dual writes: same address -> A wins; distinct addresses -> both stored
    drive(1, 20, 56'hAA, 0, 1, 20, 56'hBB, 0); tick();
    drive(0, 20, '0, 1, 0, 0, '0, 0); tick();
    chk("dual_same", q_a1, 56'hAA);
    drive(1, 21, 56'h11, 0, 1, 22, 56'h22, 0); tick();
    drive(0, 21, '0, 1, 0, 22, '0, 1); tick();
    chk("dual_a21", q_a1, 56'h11);
    chk("dual_b22", q_b1, 56'h22);

    // Asynchronous reset mid-cycle with nonzero q_b
    drive(1, 40, 56'h5A, 0, 0, 0, '0, 0); tick();
    drive(0, 0, '0, 0, 0, 40, '0, 1); tick();
    idle(); tick();
    chk("pre_rst_l2", q_b2, 56'h5A);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_l1", q_b1, '0);
    chk("async_rst_l2", q_b2, '0);
    drive(1, 41, 56'hDEAD, 0, 0, 0, '0, 0); tick();
    #2 rst_n = 1'b1;
    drive(0, 41, '0, 1, 0, 5, '0, 1); tick();
    chk("rst_write_ignored", q_a1, '0);
    chk("rst_mem_kept", q_b1, V5);

    // Boundary addresses
    drive(1, 0, 56'hC0FFEE, 0, 1, 2047, 56'hBEEF01, 0); tick();
    drive(0, 2047, '0, 1, 0, 0, '0, 1); tick();
    chk("addr_max", q_a1, 56'hBEEF01);
    chk("addr_min", q_b1, 56'hC0FFEE);

    // Random traffic over a small window to provoke collisions
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom), ($urandom_range(0, 9) == 0) ? 2047 : int'($urandom_range(0, 7)),
            {24'($urandom), 32'($urandom)}, 1'($urandom),
            1'($urandom), ($urandom_range(0, 9) == 0) ? 2047 : int'($urandom_range(0, 7)),
            {24'($urandom), 32'($urandom)}, 1'($urandom));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
